// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared channel state type, default width and select-width helper (TICK_SCHED_AUTORELOAD_EN-aware design)
package tick_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIRE} chan_state_t;
  localparam int DEF_CW = 16;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_sched_chan.sv
// tick_sched_chan: one countdown channel counting in ticks; TICK_SCHED_AUTORELOAD_EN adds periodic reload
module tick_sched_chan
  import tick_sched_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          start,
  input  logic          cancel,
`ifdef TICK_SCHED_AUTORELOAD_EN
  input  logic          periodic,
`endif
  input  logic [CW-1:0] dur,
  output logic          busy,
  output logic          expire,
  output logic [CW-1:0] remaining
);
  chan_state_t state, nstate;
  logic [CW-1:0] nrem;
`ifdef TICK_SCHED_AUTORELOAD_EN
  logic per;
  logic [CW-1:0] ldur;
`endif
  // next state: cancel beats start, start beats countdown and the FIRE exit
  always_comb begin
    nstate = state;
    nrem = remaining;
    if (cancel) begin
      nstate = IDLE;
      nrem = '0;
    end else if (start) begin
      nstate = (dur == '0) ? FIRE : RUN;
      nrem = dur;
    end else if (state == RUN && tick) begin
      nstate = (remaining == CW'(1)) ? FIRE : RUN;
      nrem = remaining - CW'(1);
    end else if (state == FIRE) begin
`ifdef TICK_SCHED_AUTORELOAD_EN
      nstate = per ? ((ldur == '0) ? FIRE : RUN) : IDLE;
      nrem = per ? ldur : '0;
`else
      nstate = IDLE;
      nrem = '0;
`endif
    end
  end
  // state, counter and decoded outputs all registered together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      busy <= 1'b0;
      expire <= 1'b0;
    end else begin
      state <= nstate;
      remaining <= nrem;
      busy <= nstate == RUN;
      expire <= nstate == FIRE;
    end
  end
`ifdef TICK_SCHED_AUTORELOAD_EN
  // periodic flag and reload value latched at start, dropped on cancel
  always_ff @(posedge clk) begin
    if (!rst_n || cancel) begin
      per <= 1'b0;
      ldur <= '0;
    end else if (start) begin
      per <= periodic;
      ldur <= dur;
    end
  end
`endif
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: free-running tick prescaler plus NCH countdown channels; TICK_SCHED_AUTORELOAD_EN adds periodic input
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TICK_DIV = 1_000_000,
  parameter int CW = DEF_CW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         start,
  input  logic [NCH-1:0]         cancel,
`ifdef TICK_SCHED_AUTORELOAD_EN
  input  logic [NCH-1:0]         periodic,
`endif
  input  logic [NCH*CW-1:0]      dur,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         expire,
  output logic                   tick,
  input  logic [sel_w(NCH)-1:0]  rd_sel,
  output logic [CW-1:0]          rd_remaining
);
  localparam int SW = sel_w(NCH);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pcnt;
  logic [CW-1:0] rem [2**SW];
  // prescaler: tick registered on the wrap so it lands TICK_DIV cycles after reset release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= pcnt == PW'(TICK_DIV - 1);
      pcnt <= (pcnt == PW'(TICK_DIV - 1)) ? '0 : pcnt + PW'(1);
    end
  end
  for (genvar i = 0; i < 2**SW; i++) begin : g_ch
    if (i < NCH) begin : g_on
      tick_sched_chan #(.CW(CW)) u_chan (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .start(start[i]),
        .cancel(cancel[i]),
`ifdef TICK_SCHED_AUTORELOAD_EN
        .periodic(periodic[i]),
`endif
        .dur(dur[i*CW +: CW]),
        .busy(busy[i]),
        .expire(expire[i]),
        .remaining(rem[i])
      );
    end else begin : g_off
      assign rem[i] = '0;
    end
  end
  assign rd_remaining = rem[rd_sel];
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: table-driven and directed checks of tick_scheduler (TICK_DIV=4, NCH=4, CW=8)
module tb_tick_scheduler;
  localparam int NCH = 4, TD = 4, CW = 8;
  logic clk = 1'b0, rst_n = 1'b0, tick;
  logic [NCH-1:0] start = '0, cancel = '0, busy, expire;
  logic [NCH*CW-1:0] dur = '0;
  logic [1:0] rd_sel = '0;
  logic [CW-1:0] rd_remaining;
`ifdef TICK_SCHED_AUTORELOAD_EN
  logic [NCH-1:0] periodic = '0;
`endif
  int total = 0, bad = 0;
  typedef struct {
    logic [3:0] st, cn;
    logic [31:0] d;
    logic [1:0] rs;
    logic [3:0] eb, ee;
    logic et;
    logic [7:0] er;
  } vec_t;
  vec_t v[30];
  tick_scheduler #(.NCH(NCH), .TICK_DIV(TD), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cancel(cancel),
`ifdef TICK_SCHED_AUTORELOAD_EN
    .periodic(periodic),
`endif
    .dur(dur),
    .busy(busy),
    .expire(expire),
    .tick(tick),
    .rd_sel(rd_sel),
    .rd_remaining(rd_remaining)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic [3:0] st, cn, input logic [31:0] d, input logic [1:0] rs,
                              input logic [3:0] eb, ee, input logic et, input logic [7:0] er);
    vec_t x;
    x.st = st; x.cn = cn; x.d = d; x.rs = rs; x.eb = eb; x.ee = ee; x.et = et; x.er = er;
    return x;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int found, t_last, n;
    v[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    v[1]  = mk(1, 0, 3, 0, 1, 0, 0, 3);
    v[2]  = mk(0, 0, 0, 0, 1, 0, 0, 3);
    v[3]  = mk(0, 0, 0, 0, 1, 0, 1, 3);
    v[4]  = mk(0, 0, 0, 0, 1, 0, 0, 2);
    v[5]  = mk(0, 0, 0, 0, 1, 0, 0, 2);
    v[6]  = mk(0, 0, 0, 0, 1, 0, 0, 2);
    v[7]  = mk(0, 0, 0, 0, 1, 0, 1, 2);
    v[8]  = mk(0, 0, 0, 0, 1, 0, 0, 1);
    v[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1);
    v[10] = mk(0, 0, 0, 0, 1, 0, 0, 1);
    v[11] = mk(0, 0, 0, 0, 1, 0, 1, 1);
    v[12] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    v[13] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    v[14] = mk(2, 0, 0, 1, 0, 2, 0, 0);
    v[15] = mk(0, 0, 0, 1, 0, 0, 1, 0);
    v[16] = mk(4, 0, 32'h0005_0000, 2, 4, 0, 0, 5);
    v[17] = mk(0, 0, 0, 2, 4, 0, 0, 5);
    v[18] = mk(0, 0, 0, 2, 4, 0, 0, 5);
    v[19] = mk(0, 0, 0, 2, 4, 0, 1, 5);
    v[20] = mk(0, 0, 0, 2, 4, 0, 0, 4);
    v[21] = mk(0, 0, 0, 2, 4, 0, 0, 4);
    v[22] = mk(0, 0, 0, 2, 4, 0, 0, 4);
    v[23] = mk(0, 0, 0, 2, 4, 0, 1, 4);
    v[24] = mk(0, 0, 0, 2, 4, 0, 0, 3);
    v[25] = mk(0, 4, 0, 2, 0, 0, 0, 0);
    v[26] = mk(0, 0, 0, 2, 0, 0, 0, 0);
    v[27] = mk(0, 0, 0, 2, 0, 0, 1, 0);
    v[28] = mk(4, 4, 32'h0005_0000, 2, 0, 0, 0, 0);
    v[29] = mk(0, 0, 0, 2, 0, 0, 0, 0);
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_expire", expire, 0);
    chk("rst_remaining", rd_remaining, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("tick_c%0d", k), tick, (k % TD == 0));
      chk($sformatf("idle_busy_c%0d", k), busy, 0);
      chk($sformatf("idle_expire_c%0d", k), expire, 0);
    end
    for (int r = 0; r < 30; r++) begin
      start = v[r].st; cancel = v[r].cn; dur = v[r].d; rd_sel = v[r].rs;
      step();
      chk($sformatf("vec%0d_busy", r), busy, v[r].eb);
      chk($sformatf("vec%0d_expire", r), expire, v[r].ee);
      chk($sformatf("vec%0d_tick", r), tick, v[r].et);
      chk($sformatf("vec%0d_remaining", r), rd_remaining, v[r].er);
    end
    start = 0; cancel = 0; dur = 0; rd_sel = 0;
    start = 4'b0001; dur = 32'd2;
    step();
    start = 0;
    chk("restart_load", rd_remaining, 2);
    step();
    step();
    chk("restart_dec", rd_remaining, 1);
    step();
    step();
    step();
    chk("restart_tick_phase", tick, 1);
    start = 4'b0001; dur = 32'd4;
    step();
    start = 0;
    chk("restart_reload", rd_remaining, 4);
    chk("restart_expire", expire, 0);
    chk("restart_busy", busy, 4'b0001);
    step();
    chk("restart_hold", rd_remaining, 4);
    cancel = 4'b0001;
    step();
    cancel = 0;
    start = 4'b1001; dur = 32'h0200_0002;
    step();
    start = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (expire != 0) begin
        found = 1;
        chk("coinc_expire", expire, 4'b1001);
        chk("coinc_busy", busy, 0);
      end
    end
    chk("coinc_found", found, 1);
    step();
    start = 4'b0010; dur = 32'h0000_0500; rd_sel = 1;
    step();
    start = 0;
    step();
    step();
    chk("mid_run_busy", busy, 4'b0010);
    rst_n = 1'b0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_expire", expire, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_remaining", rd_remaining, 0);
    rst_n = 1'b1;
    found = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (expire != 0) found = 1;
    end
    chk("midrst_silent", found, 0);
`ifdef TICK_SCHED_AUTORELOAD_EN
    periodic = 4'b0001; start = 4'b0001; dur = 32'd2; rd_sel = 0;
    step();
    start = 0; periodic = 0;
    t_last = -1; n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (expire[0]) begin
        if (t_last >= 0) chk("auto_period", c - t_last, 8);
        t_last = c;
        n++;
      end
    end
    chk("auto_count", n >= 4, 1);
    cancel = 4'b0001;
    step();
    cancel = 0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (expire != 0 || busy != 0) found = 1;
    end
    chk("auto_cancel", found, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
